unified_mem_arbiter: RTL and testbench
======================================

Name: unified_mem_arbiter

Overview:
- Shares one single-ported, fixed-latency unified memory between the instruction-fetch stage (read only) and the MEM stage (load/store).
- Sits between the PC/IF_ID front end, the EX_MEM/MEM_WB back end and the memory macro.
- Sequences each access through issue, wait and return states.
- Raises per-requester stall lines that the hazard unit ORs into pc_write/ifid_write and the pipeline freeze.

Parameters:
ADDR_W, 32, address width of all address ports
DATA_W, 32, data width of all data ports
MEM_LAT, 2, cycles from the mem_en cycle to the cycle in which mem_rdata is valid; legal range 1 to 15
STARVE_LIMIT, 3, consecutive contended grants the data port may win before the fetch port is forced a grant; legal range 1 to 15

Ports:
clk  in  1  clock; all state changes on its rising edge
rst  in  1  synchronous, active-high reset
if_req  in  1  fetch request; level, held until if_valid
if_addr  in  ADDR_W  fetch address
if_rdata  out  DATA_W  fetched word; holds its value until the next fetch completes
if_valid  out  1  one-cycle fetch completion pulse
d_req  in  1  data request; level, held until d_valid
d_we  in  1  1 = store, 0 = load
d_addr  in  ADDR_W  data address
d_wdata  in  DATA_W  store data
d_rdata  out  DATA_W  load data; holds its value until the next load completes
d_valid  out  1  one-cycle completion pulse for a load or store
mem_en  out  1  memory access strobe, one cycle per transaction
mem_we  out  1  write enable; qualified by mem_en
mem_addr  out  ADDR_W  registered access address
mem_wdata  out  DATA_W  registered write data
mem_rdata  in  DATA_W  memory read data; valid exactly MEM_LAT cycles after mem_en
stall_if  out  1  if_req & ~if_valid (combinational)
stall_d  out  1  d_req & ~d_valid (combinational)

Behaviour:
- Reset: state=IDLE; latency counter=0; starvation counter=0; owner=none.
- Reset clears to 0: mem_en, mem_we, mem_addr, mem_wdata, if_valid, d_valid, if_rdata, d_rdata.
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE, no requests: remain in IDLE.
- IDLE, at least one request: pick the owner, latch addr/we/wdata into the mem_* registers, go to ISSUE.
- Arbitration:
  - Only one requester active: it wins.
  - Both active: the data port wins unless starve_cnt == STARVE_LIMIT; then the fetch port wins.
- starve_cnt update:
  - Data wins a contended grant: starve_cnt increments (saturating at STARVE_LIMIT).
  - Fetch wins any grant: starve_cnt clears.
  - Uncontended data grant: starve_cnt unchanged.
- ISSUE:
  - mem_en=1 for exactly this cycle; mem_we=1 only for a data store.
  - Latency counter loads MEM_LAT-1; go to WAIT.
  - For MEM_LAT=1, go straight to capture: WAIT is entered with the counter at 0.
- WAIT:
  - Counter decrements each cycle.
  - In the cycle the counter is 0 (the mem_rdata-valid cycle), the owner's rdata register captures mem_rdata on the edge (loads and fetches only; stores leave d_rdata unchanged); go to DONE.
- DONE: owner's valid=1 for this one cycle; go to IDLE.
- Requests are not sampled in DONE, because the completing request is still asserted.
- Latency: request visible in IDLE at cycle 0 → ISSUE at cycle 1 → valid at cycle 2+MEM_LAT.
- Back-to-back throughput: one transaction per MEM_LAT+3 cycles.
- Captured address/data isolate the memory from requester changes after grant.
- A request dropped before its valid pulse is a protocol violation; the transaction still completes and the valid pulse is still emitted.
- Outside their one-cycle slots: mem_en=0, mem_we=0, if_valid=0, d_valid=0. if_valid and d_valid are never high in the same cycle.
- stall_if/stall_d:
  - Combinational from the req inputs and the registered valid outputs.
  - A requester that is not granted sees its stall held high for the full duration of the other port's transaction.
- rst asserted in any state:
  - Next cycle: IDLE with all outputs at reset values.
  - Any in-flight memory result is discarded and no valid pulse is emitted.
  - starve_cnt clears.
- rst and a request in the same cycle: reset wins; the request is arbitrated in the first post-reset IDLE cycle.

Test Plan:
- Single fetch, MEM_LAT=2: if_req=1, if_addr=0x40 at cycle 0, memory returns 0x8C010004 → mem_en=1 only in cycle 1 with mem_addr=0x40, mem_we=0; if_valid=1 only in cycle 4 with if_rdata=0x8C010004; stall_if=1 in cycles 0–3, 0 in cycle 4.
- Store then load, MEM_LAT=2:
  - Store d_we=1, d_addr=0x100, d_wdata=0xDEADBEEF → mem_we=1 with mem_wdata=0xDEADBEEF in the issue cycle; d_valid pulses; d_rdata unchanged.
  - Following load of 0x100, with the memory model returning 0xDEADBEEF → d_rdata=0xDEADBEEF.
- Contention:
  - if_req and d_req both held high continuously, STARVE_LIMIT=3 → grant order D,D,D,I,D,D,D,I.
  - stall_if stays high through every D transaction.
  - No cycle has if_valid & d_valid.
- MEM_LAT=1 and MEM_LAT=15 builds, single load → valid exactly 3 and 17 cycles after the request cycle; mem_en is high for exactly one cycle.
- Reset mid-transaction: rst=1 in the first WAIT cycle of a load → no d_valid ever; mem_en=0; state IDLE; the held d_req is re-issued starting in the cycle after rst deasserts.
- Address change after grant: if_addr changed from 0x40 to 0x80 in the cycle after the request cycle → mem_addr remains 0x40 for the whole transaction.

Source files
------------

// File: rtl/unified_mem_arbiter.sv
// unified_mem_arbiter: shares one fixed-latency single-port memory between fetch and data ports
module unified_mem_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int MEM_LAT      = 2,
  parameter int STARVE_LIMIT = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_valid,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_valid,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              stall_if,
  output logic              stall_d
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
  localparam logic [3:0] LAT_M1 = 4'(MEM_LAT - 1);
  localparam logic [3:0] SLIM = 4'(STARVE_LIMIT);
  state_t state_q, state_d;
  logic [3:0] lat_q, lat_d, starve_q, starve_d;
  logic own_if_q, own_if_d, own_dp_q, own_dp_d, store_q, store_d;
  logic mem_en_q, mem_en_d, mem_we_q, mem_we_d;
  logic if_valid_q, if_valid_d, d_valid_q, d_valid_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d, if_rdata_q, if_rdata_d, d_rdata_q, d_rdata_d;
  logic pick_d, grab, capture;
  always_comb begin
    pick_d = d_req & ~(if_req & (starve_q == SLIM));
    grab = (state_q == IDLE) & (if_req | d_req);
    capture = (state_q == WAIT) & (lat_q == 4'd0);
    state_d = state_q == IDLE ? (grab ? ISSUE : IDLE) :
              state_q == ISSUE ? WAIT :
              state_q == WAIT ? (capture ? DONE : WAIT) : IDLE;
    lat_d = state_q == ISSUE ? LAT_M1 : (state_q == WAIT && lat_q != 4'd0) ? lat_q - 4'd1 : lat_q;
    starve_d = ~grab ? starve_q : ~pick_d ? 4'd0 : if_req ? starve_q + 4'd1 : starve_q;
    own_if_d = grab ? ~pick_d : state_q == DONE ? 1'b0 : own_if_q;
    own_dp_d = grab ? pick_d : state_q == DONE ? 1'b0 : own_dp_q;
    store_d = grab ? pick_d & d_we : store_q;
    mem_en_d = grab;
    mem_we_d = grab & pick_d & d_we;
    mem_addr_d = grab ? (pick_d ? d_addr : if_addr) : mem_addr_q;
    mem_wdata_d = (grab & pick_d) ? d_wdata : mem_wdata_q;
    if_valid_d = capture & own_if_q;
    d_valid_d = capture & own_dp_q;
    if_rdata_d = (capture & own_if_q) ? mem_rdata : if_rdata_q;
    d_rdata_d = (capture & own_dp_q & ~store_q) ? mem_rdata : d_rdata_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      lat_q <= '0;
      starve_q <= '0;
      own_if_q <= 1'b0;
      own_dp_q <= 1'b0;
      store_q <= 1'b0;
      mem_en_q <= 1'b0;
      mem_we_q <= 1'b0;
      mem_addr_q <= '0;
      mem_wdata_q <= '0;
      if_valid_q <= 1'b0;
      d_valid_q <= 1'b0;
      if_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      state_q <= state_d;
      lat_q <= lat_d;
      starve_q <= starve_d;
      own_if_q <= own_if_d;
      own_dp_q <= own_dp_d;
      store_q <= store_d;
      mem_en_q <= mem_en_d;
      mem_we_q <= mem_we_d;
      mem_addr_q <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_valid_q <= if_valid_d;
      d_valid_q <= d_valid_d;
      if_rdata_q <= if_rdata_d;
      d_rdata_q <= d_rdata_d;
    end
  end
  assign mem_en = mem_en_q;
  assign mem_we = mem_we_q;
  assign mem_addr = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign if_valid = if_valid_q;
  assign d_valid = d_valid_q;
  assign if_rdata = if_rdata_q;
  assign d_rdata = d_rdata_q;
  assign stall_if = if_req & ~if_valid_q;
  assign stall_d = d_req & ~d_valid_q;
endmodule

// File: tb/tb_unified_mem_arbiter.sv
// tb_unified_mem_arbiter: directed and random checks of the arbiter against a transaction-level model
module tb_unified_mem_arbiter;
  localparam int L = 2;
  localparam int SL = 3;
  logic clk = 0;
  logic rst = 1;
  always #5 clk = ~clk;
  logic if_req = 0, d_req = 0, d_we = 0;
  logic [31:0] if_addr = 0, d_addr = 0, d_wdata = 0;
  logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;
  logic if_valid, d_valid, mem_en, mem_we, stall_if, stall_d;
  unified_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(L), .STARVE_LIMIT(SL)) dut (
    .clk(clk), .rst(rst), .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_rdata(d_rdata), .d_valid(d_valid),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .stall_if(stall_if), .stall_d(stall_d));
  logic a_req = 0, b_req = 0;
  logic a_ifv, a_dv, a_en, a_we, a_si, a_sd, b_ifv, b_dv, b_en, b_we, b_si, b_sd;
  logic [31:0] a_ifr, a_dr, a_addr, a_wd, a_rd, b_ifr, b_dr, b_addr, b_wd, b_rd;
  logic [15:0] ha = '0, hb = '0;
  int a_cnt = 0, b_cnt = 0;
  unified_mem_arbiter #(.MEM_LAT(1)) ua (
    .clk(clk), .rst(rst), .if_req(1'b0), .if_addr(32'h0), .if_rdata(a_ifr), .if_valid(a_ifv),
    .d_req(a_req), .d_we(1'b0), .d_addr(32'h8), .d_wdata(32'h0), .d_rdata(a_dr), .d_valid(a_dv),
    .mem_en(a_en), .mem_we(a_we), .mem_addr(a_addr), .mem_wdata(a_wd), .mem_rdata(a_rd),
    .stall_if(a_si), .stall_d(a_sd));
  unified_mem_arbiter #(.MEM_LAT(15)) ub (
    .clk(clk), .rst(rst), .if_req(1'b0), .if_addr(32'h0), .if_rdata(b_ifr), .if_valid(b_ifv),
    .d_req(b_req), .d_we(1'b0), .d_addr(32'h8), .d_wdata(32'h0), .d_rdata(b_dr), .d_valid(b_dv),
    .mem_en(b_en), .mem_we(b_we), .mem_addr(b_addr), .mem_wdata(b_wd), .mem_rdata(b_rd),
    .stall_if(b_si), .stall_d(b_sd));
  always @(posedge clk) begin
    ha <= {ha[14:0], a_en};
    hb <= {hb[14:0], b_en};
    a_cnt <= a_cnt + int'(a_en);
    b_cnt <= b_cnt + int'(b_en);
  end
  assign a_rd = ha[0] ? 32'h0A110001 : 32'h0;
  assign b_rd = hb[14] ? 32'h0B150015 : 32'h0;
  logic [31:0] tb_mem [256];
  logic [31:0] ref_mem [256];
  logic [L-1:0] vp = '0;
  logic [31:0] dp [L];
  int n = 0;
  always @(posedge clk) begin
    if (mem_en & mem_we) tb_mem[mem_addr[9:2]] <= mem_wdata;
    vp <= {vp[L-2:0], mem_en & ~mem_we};
    dp[0] <= tb_mem[mem_addr[9:2]];
    for (int i = 1; i < L; i++) dp[i] <= dp[i-1];
  end
  assign mem_rdata = vp[L-1] ? dp[L-1] : 32'hBADC0DE1 ^ 32'(n);
  int passed = 0, total = 0, mode = 0, t0 = 0, lat = 0;
  int free_at = 0, issue_cyc = -1, vcyc = -1, starve = 0;
  bit own_d = 0, own_we = 0, iv_seen = 0, dv_seen = 0;
  logic [31:0] own_addr = 0, own_wdata = 0, exp_if = 0, exp_d = 0;
  bit obs[$];
  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    total++;
    assert (o === e) passed++;
    else $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, o, e, n);
  endtask
  task automatic chk1(input string tag, input logic o, input logic e);
    total++;
    assert (o === e) passed++;
    else $error("FAIL %s: observed %b expected %b (cycle %0d)", tag, o, e, n);
  endtask
  function automatic logic [31:0] ra();
    return 32'($urandom_range(0, 15)) << 2;
  endfunction
  task automatic tick();
    bit ev;
    @(negedge clk);
    n++;
    ev = (n == vcyc);
    chk1("mem_en", mem_en, n == issue_cyc);
    chk1("mem_we", mem_we, n == issue_cyc && own_we);
    if (issue_cyc >= 0 && n >= issue_cyc && n <= vcyc) chk("mem_addr", mem_addr, own_addr);
    if (n == issue_cyc && own_we) begin
      chk("mem_wdata", mem_wdata, own_wdata);
      ref_mem[own_addr[9:2]] = own_wdata;
    end
    if (ev && !own_d) exp_if = ref_mem[own_addr[9:2]];
    if (ev && own_d && !own_we) exp_d = ref_mem[own_addr[9:2]];
    chk1("if_valid", if_valid, ev && !own_d);
    chk1("d_valid", d_valid, ev && own_d);
    chk1("valid_excl", if_valid & d_valid, 1'b0);
    chk("if_rdata", if_rdata, exp_if);
    chk("d_rdata", d_rdata, exp_d);
    if (if_valid | d_valid) obs.push_back(d_valid);
    iv_seen = if_valid;
    dv_seen = d_valid;
  endtask
  task automatic commit();
    bit pd;
    #1;
    chk1("stall_if", stall_if, if_req && !(n == vcyc && !own_d));
    chk1("stall_d", stall_d, d_req && !(n == vcyc && own_d));
    if (rst) begin
      free_at = n + 1;
      issue_cyc = -1;
      vcyc = -1;
      starve = 0;
      exp_if = 0;
      exp_d = 0;
    end else if (n >= free_at && (if_req || d_req)) begin
      pd = d_req && !(if_req && starve == SL);
      own_d = pd;
      own_we = pd && d_we;
      own_addr = pd ? d_addr : if_addr;
      own_wdata = d_wdata;
      issue_cyc = n + 1;
      vcyc = n + 2 + L;
      free_at = n + 3 + L;
      starve = !pd ? 0 : if_req ? (starve < SL ? starve + 1 : SL) : starve;
    end
  endtask
  task automatic go();
    if (mode != 1) begin
      if (iv_seen) if_req = 0;
      if (dv_seen) d_req = 0;
    end
    if (mode == 2) begin
      rst = ($urandom_range(0, 149) == 0);
      if (!if_req && $urandom_range(0, 2) == 0) begin
        if_req = 1;
        if_addr = ra();
      end else if ($urandom_range(0, 3) == 0) if_addr = ra();
      if (!d_req && $urandom_range(0, 2) == 0) begin
        d_req = 1;
        d_we = 1'($urandom_range(0, 1));
        d_addr = ra();
        d_wdata = $urandom;
      end else if ($urandom_range(0, 3) == 0) d_addr = ra();
    end
    commit();
  endtask
  task automatic cyc();
    tick();
    go();
  endtask
  task automatic wait_valid(input bit want_d, output int l);
    l = -1;
    for (int k = 0; k < 40 && l < 0; k++) begin
      tick();
      if (want_d ? dv_seen : iv_seen) l = n - t0;
      go();
    end
  endtask
  initial begin
    int la, lb;
    bit [7:0] pat;
    for (int i = 0; i < 256; i++) begin
      tb_mem[i] = 32'(i) * 32'h9E3779B1 ^ 32'h5A5A5A5A;
      ref_mem[i] = tb_mem[i];
    end
    tb_mem[16] = 32'h8C010004;
    ref_mem[16] = 32'h8C010004;
    cyc();
    cyc();
    tick();
    rst = 0;
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    go();
    tick();
    if_req = 1;
    if_addr = 32'h40;
    t0 = n;
    go();
    tick();
    if_addr = 32'h80;
    go();
    wait_valid(0, lat);
    chk("fetch_latency", lat, 4);
    chk("fetch_data", if_rdata, 32'h8C010004);
    tick();
    d_req = 1;
    d_we = 1;
    d_addr = 32'h100;
    d_wdata = 32'hDEADBEEF;
    t0 = n;
    go();
    wait_valid(1, lat);
    chk("store_latency", lat, 4);
    chk("store_keeps_rdata", d_rdata, 32'h0);
    tick();
    d_req = 1;
    d_we = 0;
    t0 = n;
    go();
    wait_valid(1, lat);
    chk("load_after_store", d_rdata, 32'hDEADBEEF);
    tick();
    d_req = 1;
    d_addr = 32'h20;
    go();
    cyc();
    tick();
    rst = 1;
    go();
    tick();
    rst = 0;
    t0 = n;
    go();
    wait_valid(1, lat);
    chk("reissue_latency", lat, 4);
    chk("reissue_data", d_rdata, tb_mem[8]);
    tick();
    rst = 1;
    go();
    tick();
    rst = 0;
    mode = 1;
    if_req = 1;
    d_req = 1;
    d_we = 0;
    if_addr = 32'h40;
    d_addr = 32'h100;
    obs.delete();
    go();
    repeat (40) cyc();
    pat = 8'b0111_0111;
    chk1("grant_count", obs.size() >= 8, 1'b1);
    for (int i = 0; i < 8 && i < obs.size(); i++) chk1($sformatf("grant_%0d", i), obs[i], pat[i]);
    tick();
    mode = 0;
    if_req = 0;
    d_req = 0;
    go();
    repeat (8) cyc();
    tick();
    a_req = 1;
    b_req = 1;
    t0 = n;
    go();
    la = -1;
    lb = -1;
    for (int k = 0; k < 30; k++) begin
      tick();
      if (a_dv && la < 0) begin
        la = n - t0;
        a_req = 0;
      end
      if (b_dv && lb < 0) begin
        lb = n - t0;
        b_req = 0;
      end
      go();
    end
    chk("lat1_latency", la, 3);
    chk("lat15_latency", lb, 17);
    chk("lat1_data", a_dr, 32'h0A110001);
    chk("lat15_data", b_dr, 32'h0B150015);
    chk("lat1_mem_en_count", a_cnt, 1);
    chk("lat15_mem_en_count", b_cnt, 1);
    mode = 2;
    repeat (3000) cyc();
    tick();
    mode = 0;
    rst = 0;
    if_req = 0;
    d_req = 0;
    go();
    repeat (25) cyc();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
